// File: rtl/rf_writeback_queue.sv
// rf_writeback_queue
//
// Write-back buffer placed directly in front of the register file. Execution
// units push (address, data) write requests over a valid/ready handshake.
// The requests are held in a small circular FIFO and drained in order, at
// most one per cycle, into the register file write port. A combinational
// bypass lookup returns the youngest pending value for any register address.
// Readers therefore never see stale register contents while writes are still
// queued.
//
// Optional feature (macro WBQ_COALESCE_EN):
//   When this macro is defined, a request that targets the same address as
//   the youngest queued entry overwrites that entry's data in place. No new
//   entry is allocated. When the macro is undefined, every accepted request
//   allocates its own entry.
//
// Ports:
//   clk               clock, all state updates on the rising edge
//   clear             asynchronous active-high reset
//   in_valid          upstream write request valid
//   in_ready          queue can accept a request this cycle
//   in_addr           destination register of the request
//   in_data           data of the request
//   rf_stall          register file write port unavailable this cycle
//   rf_write_enable   register file write_enable
//   rf_write_location register file write_location
//   rf_data           register file data_in
//   lookup_addr       bypass query address
//   lookup_hit        a pending entry matches lookup_addr
//   lookup_data       data of the youngest matching pending entry
//   count             number of valid entries
//
// DEPTH must be a power of two (2..16), so the pointers wrap naturally.

module rf_writeback_queue #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     clear,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ADDR_W-1:0]        in_addr,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     rf_stall,
  output logic                     rf_write_enable,
  output logic [ADDR_W-1:0]        rf_write_location,
  output logic [DATA_W-1:0]        rf_data,
  input  logic [ADDR_W-1:0]        lookup_addr,
  output logic                     lookup_hit,
  output logic [DATA_W-1:0]        lookup_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [DEPTH-1:0]  valid_q;
  logic [PTR_W-1:0]  head_q;
  logic [PTR_W-1:0]  tail_q;
  logic [CNT_W-1:0]  count_q;

  logic full;
  logic empty;
  logic push;
  logic pop;

  assign full  = (count_q == FULL_COUNT);
  assign empty = (count_q == '0);
  assign count = count_q;

  // Draining depends only on registered occupancy and the register file stall.
  assign pop = !empty && !rf_stall;

`ifdef WBQ_COALESCE_EN
  logic [PTR_W-1:0] tail_m1;
  logic             coalesce_ok;
  logic             coalesce;

  assign tail_m1 = tail_q - 1'b1;

  // The youngest entry may absorb a same-address request. This is not allowed
  // when it is also the head and is being written out this cycle, because the
  // new data would then be lost. In that case the request allocates normally.
  assign coalesce_ok = !empty && (addr_mem[tail_m1] == in_addr) &&
                       !(pop && (count_q == CNT_W'(1)));
  assign in_ready    = !clear && (!full || coalesce_ok);
  assign coalesce    = in_valid && in_ready && coalesce_ok;
  assign push        = in_valid && in_ready && !coalesce_ok;
`else
  assign in_ready = !clear && !full;
  assign push     = in_valid && in_ready;
`endif

  // The head entry is presented only when something is queued. Otherwise the
  // write port sees zeros.
  assign rf_write_enable   = pop;
  assign rf_write_location = empty ? '0 : addr_mem[head_q];
  assign rf_data           = empty ? '0 : data_mem[head_q];

  // The scan runs from the head toward the tail. A later match overrides an
  // earlier one, so the youngest matching entry wins.
  logic [PTR_W-1:0] scan_idx;
  always_comb begin
    lookup_hit  = 1'b0;
    lookup_data = '0;
    scan_idx    = head_q;
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx = head_q + PTR_W'(i);
      if (valid_q[scan_idx] && (addr_mem[scan_idx] == lookup_addr)) begin
        lookup_hit  = 1'b1;
        lookup_data = data_mem[scan_idx];
      end
    end
  end

  // Pointers, occupancy, valid bits and storage. Push and pop in the same
  // cycle never target the same slot: that would need count 0 (no pop) or
  // count DEPTH (no push).
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_mem[i] <= '0;
        data_mem[i] <= '0;
      end
    end else begin
      if (push) begin
        addr_mem[tail_q] <= in_addr;
        data_mem[tail_q] <= in_data;
        valid_q[tail_q]  <= 1'b1;
        tail_q           <= tail_q + 1'b1;
      end
`ifdef WBQ_COALESCE_EN
      if (coalesce) begin
        data_mem[tail_m1] <= in_data;
      end
`endif
      if (pop) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule
